mn_pipe_arbiter: RTL

Round-robin arbiter that shares the 8-bit m→n nibble-swap datapath (`i`) among `NUM_REQ` requesters. It issues at most one byte per cycle into the datapath and tracks each issued byte's requester ID through a tag pipeline matched to the datapath latency. It returns each result tagged with its ID. It sits directly in front of `i`: `dp_data_in` drives `i.data_in`, and `i.data_out` returns on `dp_data_out`.

---
 rtl/mn_pipe_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mn_pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-latency nibble-swap datapath, with an ID tag pipeline,
// registered results and a flush/drain FSM. Define MN_ARB_PRIO_EN for strict priority on requester 0.
//   state    | meaning
//   ST_RUN   | grants allowed; flush moves to ST_DRAIN
//   ST_DRAIN | no grants; waits for in-flight count to reach 0, then pulses flush_done
module mn_pipe_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 busy,
    output logic [7:0]           dp_data_in,
    input  logic [7:0]           dp_data_out,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [7:0]           res_data
);

    localparam int CW = $clog2(PIPE_LAT + 2);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                grant_en;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0]      tag_id_q [PIPE_LAT];
    logic [IDW-1:0]      tag_id_d [PIPE_LAT];
    logic                res_valid_q, res_valid_d;
    logic [IDW-1:0]      res_id_q, res_id_d;
    logic [7:0]          res_data_q, res_data_d;
    logic [7:0]          req_bytes [NUM_REQ];
    logic                win_found, rr_upd, xfer, res_load;
    logic [IDW-1:0]      win_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        grant_en   = (state_q == ST_RUN);
        flush_done = (state_q == ST_DRAIN) && (cnt_q == '0);
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int             slot;
        logic [IDW-1:0] idx;
        slot      = 0;
        idx       = '0;
        win_found = 1'b0;
        win_id    = '0;
        rr_upd    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(rr_ptr_q) + i;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            idx = IDW'(slot);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
`ifdef MN_ARB_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_id    = '0;
            rr_upd    = 1'b0;
        end
`endif
    end

    // Gating with rst_n keeps req_ready and dp_data_in at 0 while reset is held.
    assign xfer     = grant_en && win_found && rst_n;
    assign res_load = tag_vld_q[PIPE_LAT-1];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) req_bytes[k] = req_data[8*k +: 8];
        req_ready = '0;
        if (xfer) req_ready[win_id] = 1'b1;
        dp_data_in = xfer ? req_bytes[win_id] : 8'h00;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && rr_upd) begin
            rr_ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
        end

        cnt_d = cnt_q;
        if (xfer && !res_load)      cnt_d = cnt_q + CW'(1);
        else if (!xfer && res_load) cnt_d = cnt_q - CW'(1);

        tag_vld_d = '0;
        for (int s = 0; s < PIPE_LAT; s++) tag_id_d[s] = '0;
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = xfer ? win_id : '0;
        for (int s = 1; s < PIPE_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        res_valid_d = res_load;
        res_id_d    = res_load ? tag_id_q[PIPE_LAT-1] : '0;
        res_data_d  = res_load ? dp_data_out : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            tag_vld_q   <= '0;
            for (int s = 0; s < PIPE_LAT; s++) tag_id_q[s] <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= 8'h00;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            tag_vld_q   <= tag_vld_d;
            for (int s = 0; s < PIPE_LAT; s++) tag_id_q[s] <= tag_id_d[s];
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy      = (cnt_q != '0);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

endmodule
